// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared N-to-1 bit mux.
// One requester is granted at a time. A grant ends when the grantee drops
// its request, pulses done, or has held the mux for MAX_HOLD cycles. On a
// release the next winner is chosen on the same edge, searching from the
// slot after the released one, so there is no idle bubble between grants.
module mux_rr_arbiter #(
  parameter int N        = 32,
  parameter int SELW     = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N-1:0]                req,
  input  logic                        done,
  output logic [N-1:0]                gnt,
  output logic [SELW-1:0]             sel,
  output logic                        gnt_valid,
  output logic [$clog2(MAX_HOLD):0]   hold_cnt
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
  localparam logic [N-1:0]  ONE_HOT_0  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  logic [SELW-1:0] ptr, ptr_n;
  logic [SELW-1:0] sel_n;
  logic [N-1:0]    gnt_n;
  logic [CW-1:0]   hold_n;

  logic            release_now;
  logic            found;
  logic [SELW-1:0] win;
  int              start;

  // Registers for FSM state, pointer and all outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every register sample the same
    // pre-edge values, which is what makes this a clean synchronous update.
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      gnt      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      gnt      <= gnt_n;
      hold_cnt <= hold_n;
    end
  end

  // Release detection, rotating priority search and next-state/output logic.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_n     = state;
    ptr_n       = ptr;
    sel_n       = sel;
    hold_n      = hold_cnt;
    found       = 1'b0;
    win         = '0;

    release_now = (state == GRANT) &&
                  (!req[sel] || done || (hold_cnt == HOLD_LIMIT));

    // From IDLE the search starts at ptr; on a release it starts just past
    // the released grantee, which is also the value ptr is about to take.
    start = (state == GRANT) ? ((int'(sel) + 1) % N) : int'(ptr);

    for (int k = 0; k < N; k++) begin
      automatic int idx = (start + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = SELW'(idx);
      end
    end

    case (state)
      IDLE: begin
        hold_n = '0;
        if (found) begin
          state_n = GRANT;
          sel_n   = win;
          hold_n  = CW'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_n = SELW'(start);
          if (found) begin
            sel_n  = win;
            hold_n = CW'(1);
          end else begin
            state_n = IDLE;
            hold_n  = '0;
          end
        end else if (hold_cnt != HOLD_LIMIT) begin
          hold_n = hold_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    gnt_n = (state_n == GRANT) ? (ONE_HOT_0 << sel_n) : '0;
  end

  assign gnt_valid = (state == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a directed vector table, hand
// sequences for timeout / wrap / reset-mid-grant, then random traffic
// compared against a behavioural model of the arbitration rules.
module tb_mux_rr_arbiter;

  localparam int N        = 32;
  localparam int SELW     = 5;
  localparam int MAX_HOLD = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N-1:0]              req;
  logic                      done;
  logic [N-1:0]              gnt;
  logic [SELW-1:0]           sel;
  logic                      gnt_valid;
  logic [$clog2(MAX_HOLD):0] hold_cnt;

  int errors = 0;
  int checks = 0;

  mux_rr_arbiter #(.N(N), .SELW(SELW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .hold_cnt  (hold_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: who holds the mux, for how long, and where the
  // round-robin search resumes.
  bit m_valid;
  int m_sel, m_cnt, m_ptr;

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic model_edge(input bit r_rst, input logic [N-1:0] r, input bit d);
    int w;
    if (r_rst) begin
      m_valid = 0; m_sel = 0; m_cnt = 0; m_ptr = 0;
    end else if (!m_valid) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin m_valid = 1; m_sel = w; m_cnt = 1; end
    end else if (!r[m_sel] || d || m_cnt == MAX_HOLD) begin
      m_ptr = (m_sel + 1) % N;
      w = pick(r, m_ptr);
      if (w >= 0) begin m_sel = w; m_cnt = 1; end
      else begin m_valid = 0; m_cnt = 0; end
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, and advance the model in lockstep.
  task automatic step(input bit r_rst, input logic [N-1:0] r, input bit d);
    rst = r_rst; req = r; done = d;
    @(posedge clk);
    model_edge(r_rst, r, d);
    #1;
  endtask

  task automatic expect_out(input string tag, input bit v, input int s, input int c);
    logic [N-1:0] eg;
    eg = v ? (N'(1) << s) : '0;
    check({tag, " gnt_valid"}, 32'(gnt_valid), 32'(v));
    check({tag, " sel"},       32'(sel),       32'(s));
    check({tag, " gnt"},       gnt,            eg);
    check({tag, " hold_cnt"},  32'(hold_cnt),  32'(c));
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] req;
    bit           done;
    bit           valid;
    int           sel;
    int           cnt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; req = '0; done = 1'b0;

    // Reset, single requester, fairness order 0,4,31 and idle done.
    vecs.push_back('{1, 32'hFFFF_FFFF, 0, 0, 0,  0});
    vecs.push_back('{1, 32'hFFFF_FFFF, 0, 0, 0,  0});
    vecs.push_back('{0, 32'hFFFF_FFFF, 0, 1, 0,  1});
    vecs.push_back('{0, 32'h0000_0000, 0, 0, 0,  0});
    vecs.push_back('{0, 32'h0000_0008, 0, 1, 3,  1});
    vecs.push_back('{0, 32'h0000_0000, 0, 0, 3,  0});
    vecs.push_back('{1, 32'h0000_0000, 0, 0, 0,  0});
    vecs.push_back('{0, 32'h8000_0011, 0, 1, 0,  1});
    vecs.push_back('{0, 32'h8000_0011, 1, 1, 4,  1});
    vecs.push_back('{0, 32'h8000_0011, 1, 1, 31, 1});
    vecs.push_back('{0, 32'h8000_0011, 1, 1, 0,  1});
    vecs.push_back('{0, 32'h8000_0011, 1, 1, 4,  1});
    vecs.push_back('{0, 32'h8000_0011, 1, 1, 31, 1});
    vecs.push_back('{0, 32'h0000_0000, 0, 0, 31, 0});
    vecs.push_back('{0, 32'h0000_0000, 1, 0, 31, 0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      expect_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].sel, vecs[i].cnt);
    end

    // Timeout ping-pong between requesters 1 and 2.
    step(1, '0, 0);
    for (int t = 1; t <= 24; t++) begin
      step(0, 32'h0000_0006, 0);
      expect_out($sformatf("timeout t%0d", t), 1,
                 ((t - 1) / MAX_HOLD) % 2 == 0 ? 1 : 2, ((t - 1) % MAX_HOLD) + 1);
    end

    // Wrap: requester 31 times out, is re-granted, and ptr wraps to 0.
    step(1, '0, 0);
    for (int t = 1; t <= MAX_HOLD + 1; t++) begin
      step(0, 32'h8000_0000, 0);
      expect_out($sformatf("wrap t%0d", t), 1, 31, t <= MAX_HOLD ? t : 1);
    end
    step(0, '0, 0);
    expect_out("wrap idle", 0, 31, 0);
    step(0, 32'h8000_0001, 0);
    expect_out("wrap ptr0", 1, 0, 1);

    // Reset in the middle of a grant.
    step(1, '0, 0);
    for (int t = 1; t <= 3; t++) begin
      step(0, 32'h0000_0020, 0);
      expect_out($sformatf("midrst t%0d", t), 1, 5, t);
    end
    step(1, 32'h0000_0020, 0);
    expect_out("midrst reset", 0, 0, 0);
    step(0, 32'h0000_0020, 0);
    expect_out("midrst regrant", 1, 5, 1);

    // Random traffic against the model; sparse masks make contention and
    // request drops both common.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = N'(1) << $urandom_range(0, N - 1);
        2: r = $urandom() & $urandom() & $urandom();
        default: r = $urandom();
      endcase
      step($urandom_range(0, 49) == 0, r, $urandom_range(0, 3) == 0);
      expect_out($sformatf("rand%0d", i), m_valid, m_sel, m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
